// File: rtl/systolic_fir_filter_if.sv
// Sample, coefficient and result bundle for systolic_fir_filter.
// The DUT takes the slave side; a driver takes the master side.
interface systolic_fir_filter_if #(
    parameter int DataWidth  = 18,
    parameter int CoeffWidth = 18,
    parameter int TapCount   = 16,
    parameter int OutWidth   = 48
);
    localparam int AddrWidth = $clog2(TapCount);

    logic signed [DataWidth-1:0]  Data_i;
    logic                         DataNd_i;
    logic                         Clear_i;
    logic                         CoeffWe_i;
    logic [AddrWidth-1:0]         CoeffAddr_i;
    logic signed [CoeffWidth-1:0] CoeffData_i;
    logic signed [OutWidth-1:0]   Data_o;
    logic                         DataValid_o;
    logic                         Sat_o;
    logic                         SatSticky_o;

    modport master (
        output Data_i, DataNd_i, Clear_i, CoeffWe_i, CoeffAddr_i, CoeffData_i,
        input  Data_o, DataValid_o, Sat_o, SatSticky_o
    );

    modport slave (
        input  Data_i, DataNd_i, Clear_i, CoeffWe_i, CoeffAddr_i, CoeffData_i,
        output Data_o, DataValid_o, Sat_o, SatSticky_o
    );
endinterface

// File: rtl/systolic_fir_filter.sv
// Systolic FIR: per-tap two-register sample delay, product and partial-sum stages,
// each advanced once per accepted sample, followed by a round/saturate output stage.
module systolic_fir_tap #(
    parameter int DataWidth  = 18,
    parameter int CoeffWidth = 18,
    parameter int AccWidth   = 40
) (
    input  logic                         Clk_i,
    input  logic                         Rst_i,
    input  logic                         i_clr,
    input  logic                         i_en0,
    input  logic                         i_en1,
    input  logic                         i_en2,
    input  logic                         i_we,
    input  logic signed [CoeffWidth-1:0] i_coef,
    input  logic signed [DataWidth-1:0]  i_x,
    output logic signed [DataWidth-1:0]  o_x,
    input  logic signed [AccWidth-1:0]   i_ps,
    output logic signed [AccWidth-1:0]   o_ps
);
    localparam int PW = DataWidth + CoeffWidth;

    logic signed [CoeffWidth-1:0] r_coef;
    logic signed [DataWidth-1:0]  r_xa, r_xb;
    logic signed [PW-1:0]         r_prd;
    logic signed [AccWidth-1:0]   r_ps;

    // Coefficients survive Clear_i; only the data path is flushed.
    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            r_coef <= '0;
            r_xa   <= '0;
            r_xb   <= '0;
            r_prd  <= '0;
            r_ps   <= '0;
        end else begin
            if (i_we) r_coef <= i_coef;
            if (i_clr) begin
                r_xa  <= '0;
                r_xb  <= '0;
                r_prd <= '0;
                r_ps  <= '0;
            end else begin
                if (i_en0) begin
                    r_xa <= i_x;
                    r_xb <= r_xa;
                end
                if (i_en1) r_prd <= r_xa * r_coef;
                if (i_en2) r_ps  <= i_ps + AccWidth'(r_prd);
            end
        end
    end

    assign o_x  = r_xb;
    assign o_ps = r_ps;
endmodule

module systolic_fir_filter #(
    parameter int DataWidth  = 18,
    parameter int CoeffWidth = 18,
    parameter int TapCount   = 16,
    parameter int OutWidth   = 48,
    parameter int OutShift   = 0
) (
    input logic Clk_i,
    input logic Rst_i,
    systolic_fir_filter_if.slave io
);
    localparam int AddrWidth = $clog2(TapCount);
    localparam int AccWidth  = DataWidth + CoeffWidth + AddrWidth;
    // Extra headroom so the rounding add can never wrap.
    localparam int RW        = AccWidth + OutShift + 1;
    localparam logic signed [RW-1:0] RND = RW'((64'd1 << OutShift) >> 1);

    logic signed [DataWidth-1:0] w_x  [TapCount+1];
    logic signed [AccWidth-1:0]  w_ps [TapCount+1];
    logic                        w_nd;
    logic [3:1]                  r_vld_pipe;
    logic signed [RW-1:0]        w_rnd, w_shf;
    logic signed [OutWidth-1:0]  w_out;
    logic                        w_sat;
    logic signed [OutWidth-1:0]  r_data;
    logic                        r_valid, r_sat, r_sticky;

    assign w_x[0]  = io.Data_i;
    assign w_ps[0] = '0;
    assign w_nd    = io.DataNd_i & ~io.Clear_i;

    for (genvar k = 0; k < TapCount; k++) begin : g_tap
        systolic_fir_tap #(
            .DataWidth (DataWidth),
            .CoeffWidth(CoeffWidth),
            .AccWidth  (AccWidth)
        ) u_tap (
            .Clk_i (Clk_i),
            .Rst_i (Rst_i),
            .i_clr (io.Clear_i),
            .i_en0 (w_nd),
            .i_en1 (r_vld_pipe[1]),
            .i_en2 (r_vld_pipe[2]),
            .i_we  (io.CoeffWe_i && (io.CoeffAddr_i == AddrWidth'(k))),
            .i_coef(io.CoeffData_i),
            .i_x   (w_x[k]),
            .o_x   (w_x[k+1]),
            .i_ps  (w_ps[k]),
            .o_ps  (w_ps[k+1])
        );
    end

    assign w_rnd = RW'(w_ps[TapCount]) + RND;
    assign w_shf = w_rnd >>> OutShift;

    if (OutWidth >= RW) begin : g_nosat
        assign w_sat = 1'b0;
        assign w_out = OutWidth'(w_shf);
    end else begin : g_sat
        localparam int HW = RW - OutWidth + 1;
        // In range only when every bit above the output sign bit matches it.
        assign w_sat = (w_shf[RW-1:OutWidth-1] != {HW{w_shf[RW-1]}});
        assign w_out = !w_sat       ? w_shf[OutWidth-1:0] :
                       w_shf[RW-1]  ? {1'b1, {(OutWidth-1){1'b0}}} :
                                      {1'b0, {(OutWidth-1){1'b1}}};
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            r_vld_pipe <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_sat      <= 1'b0;
            r_sticky   <= 1'b0;
        end else if (io.Clear_i) begin
            r_vld_pipe <= '0;
            r_valid    <= 1'b0;
            r_sticky   <= 1'b0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[2:1], w_nd};
            r_valid    <= r_vld_pipe[3];
            if (r_vld_pipe[3]) begin
                r_data   <= w_out;
                r_sat    <= w_sat;
                r_sticky <= r_sticky | w_sat;
            end
        end
    end

    assign io.Data_o      = r_data;
    assign io.DataValid_o = r_valid;
    assign io.Sat_o       = r_sat;
    assign io.SatSticky_o = r_sticky;
endmodule

// File: tb/tb_systolic_fir_filter.sv
// Directed bench: default-width filter with a latency/valid monitor, plus a
// 16-bit, shift-by-2 instance for saturation and rounding.
module tb_systolic_fir_filter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [17:0] d  = '0;
    logic signed [17:0] wd = '0;
    logic [3:0] wa  = '0;
    logic       nd  = 1'b0;
    logic       clr = 1'b0;
    logic       we  = 1'b0;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;
    int pend[$];
    logic signed [63:0] got[$];

    systolic_fir_filter_if #(.DataWidth(18), .CoeffWidth(18), .TapCount(16), .OutWidth(48)) f0();
    systolic_fir_filter_if #(.DataWidth(18), .CoeffWidth(18), .TapCount(16), .OutWidth(16)) f1();

    assign f0.Data_i = d;   assign f1.Data_i = d;
    assign f0.DataNd_i = nd; assign f1.DataNd_i = nd;
    assign f0.Clear_i = clr; assign f1.Clear_i = clr;
    assign f0.CoeffWe_i = we; assign f1.CoeffWe_i = we;
    assign f0.CoeffAddr_i = wa; assign f1.CoeffAddr_i = wa;
    assign f0.CoeffData_i = wd; assign f1.CoeffData_i = wd;

    systolic_fir_filter #(.DataWidth(18), .CoeffWidth(18), .TapCount(16), .OutWidth(48), .OutShift(0))
        u0 (.Clk_i(clk), .Rst_i(rst), .io(f0));
    systolic_fir_filter #(.DataWidth(18), .CoeffWidth(18), .TapCount(16), .OutWidth(16), .OutShift(2))
        u1 (.Clk_i(clk), .Rst_i(rst), .io(f1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    // Each accepted sample must produce exactly one valid four cycles later.
    always @(negedge clk) begin
        if (rst) pend.delete();
        else begin
            if (f0.DataValid_o) begin
                if (pend.size() == 0) chk("vld_spurious", 1, 0);
                else begin
                    chk("vld_latency", 64'(cyc - pend.pop_front()), 4);
                    got.push_back(64'(f0.Data_o));
                end
            end
            if (clr) pend.delete();
            else if (nd) pend.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic signed [17:0] x);
        d  = x;
        nd = 1'b1;
        tick();
        nd = 1'b0;
    endtask

    task automatic wc(input logic [3:0] a, input logic signed [17:0] v);
        wa = a;
        wd = v;
        we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic run_imp();
        got.delete();
        push(18'sd1);
        repeat (31) push(18'sd0);
        repeat (6) tick();
    endtask

    // c[k]=k+1 impulse: zeros for m<15, then 1..16, then 0.
    task automatic chk_imp(input string tag, input bit zero);
        chk({tag, "_n"}, 64'(got.size()), 32);
        for (int m = 0; m < got.size() && m < 32; m++)
            chk(tag, got[m], (zero || m < 15 || m > 30) ? 64'sd0 : 64'(m - 14));
    endtask

    int cv[4] = '{6, -6, 5, -7};
    int rv[4] = '{2, -1, 1, -2};

    initial begin
        repeat (3) tick();
        chk("rst_data", 64'(f0.Data_o), 0);
        chk("rst_valid", 64'(f0.DataValid_o), 0);
        chk("rst_sat", 64'(f0.Sat_o), 0);
        chk("rst_sticky", 64'(f0.SatSticky_o), 0);
        chk("rst_data1", 64'(f1.Data_o), 0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 16; k++) wc(4'(k), 18'(k + 1));
        run_imp();
        chk_imp("imp", 1'b0);

        for (int k = 0; k < 16; k++) wc(4'(k), 18'sd1);
        got.delete();
        repeat (40) push(18'sd100);
        repeat (6) tick();
        chk("ramp_n", 64'(got.size()), 40);
        for (int m = 0; m < got.size(); m++)
            chk("ramp", got[m], (m < 15) ? 64'sd0 : 64'(((m - 14) > 16 ? 16 : (m - 14)) * 100));

        // c[0] rewritten in the same cycle as sample 0's product stage.
        do_clear();
        for (int k = 1; k < 16; k++) wc(4'(k), 18'sd0);
        got.delete();
        push(18'sd1);
        wc(4'd0, 18'sd5);
        push(18'sd1);
        repeat (16) push(18'sd0);
        repeat (6) tick();
        chk("cw_n", 64'(got.size()), 18);
        chk("cw_old", got[15], 1);
        chk("cw_new", got[16], 5);
        chk("cw_tail", got[17], 0);

        // Clear with a strobe: the last three samples and the strobed one vanish.
        do_clear();
        for (int k = 0; k < 16; k++) wc(4'(k), 18'(k + 1));
        got.delete();
        repeat (20) push(18'sd7);
        d = 18'sd7; nd = 1'b1; clr = 1'b1;
        tick();
        nd = 1'b0; clr = 1'b0;
        repeat (6) tick();
        chk("clr_n", 64'(got.size()), 17);
        chk("clr_m15", got[15], 7);
        chk("clr_m16", got[16], 21);
        chk("clr_hold", 64'(f0.Data_o), 21);
        run_imp();
        chk_imp("imp_clr", 1'b0);

        // Asynchronous reset between edges mid-stream.
        got.delete();
        repeat (20) push(18'sd3);
        chk("pre_rst", 64'(f0.Data_o), 9);
        #3 rst = 1'b1;
        #1;
        chk("arst_data", 64'(f0.Data_o), 0);
        chk("arst_valid", 64'(f0.DataValid_o), 0);
        chk("arst_sticky", 64'(f0.SatSticky_o), 0);
        tick();
        tick();
        rst = 1'b0;
        run_imp();
        chk_imp("imp_nocoef", 1'b1);
        for (int k = 0; k < 16; k++) wc(4'(k), 18'(k + 1));
        run_imp();
        chk_imp("imp_reload", 1'b0);

        // Saturation on the narrow instance.
        do_clear();
        for (int k = 0; k < 16; k++) wc(4'(k), 18'sh1FFFF);
        repeat (20) push(18'sh1FFFF);
        repeat (6) tick();
        chk("sat_pos", 64'(f1.Data_o), 32767);
        chk("sat_flag", 64'(f1.Sat_o), 1);
        chk("sat_sticky", 64'(f1.SatSticky_o), 1);
        do_clear();
        chk("clr_sticky", 64'(f1.SatSticky_o), 0);
        chk("clr_hold1", 64'(f1.Data_o), 32767);
        repeat (20) push(-18'sd131071);
        repeat (6) tick();
        chk("sat_neg", 64'(f1.Data_o), -32768);
        chk("sat_negflag", 64'(f1.Sat_o), 1);

        for (int i = 0; i < 4; i++) begin
            do_clear();
            wc(4'd0, 18'(cv[i]));
            for (int k = 1; k < 16; k++) wc(4'(k), 18'sd0);
            push(18'sd1);
            repeat (15) push(18'sd0);
            repeat (6) tick();
            chk("round", 64'(f1.Data_o), 64'(rv[i]));
            chk("round_nosat", 64'(f1.Sat_o), 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
